// File: rtl/servo_pkg.sv
// Shared constants, conversion FSM states and width helpers
// for the servo PWM blocks.
package servo_pkg;

    localparam int DEF_PERIOD    = 1000000;
    localparam int DEF_PULSE_MIN = 50000;
    localparam int DEF_PULSE_MAX = 100000;
    localparam int DEF_PULSE_NEU = 75000;
    localparam int DEF_SLEW_STEP = 500;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREP,
        ST_DIV,
        ST_WRITE
    } conv_state_t;

    function automatic int pw_width(input int period);
        return $clog2(period + 1);
    endfunction

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle, Q_W cycles.
// Caller guarantees num < den * 2**Q_W.
module seq_divider #(
    parameter int NUM_W = 24,
    parameter int DEN_W = 12,
    parameter int Q_W   = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int CNT_W = $clog2(Q_W + 1);

    logic [DEN_W-1:0] rem_q;
    logic [DEN_W-1:0] den_q;
    logic [Q_W-1:0]   q_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [DEN_W:0]   trial;
    logic [DEN_W-1:0] diff;
    logic             fits;

    assign trial = {rem_q, q_q[Q_W-1]};
    assign fits  = trial >= {1'b0, den_q};
    assign diff  = trial[DEN_W-1:0] - den_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q  <= '0;
            den_q  <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (busy_q) begin
            rem_q <= fits ? diff : trial[DEN_W-1:0];
            q_q   <= {q_q[Q_W-2:0], fits};
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_q <= 1'b0;
            end
        end else if (start) begin
            // Upper numerator bits seed the remainder; low bits shift in.
            rem_q  <= DEN_W'(num[NUM_W-1:Q_W]);
            den_q  <= den;
            q_q    <= num[Q_W-1:0];
            cnt_q  <= CNT_W'(Q_W);
            busy_q <= 1'b1;
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (cnt_q == CNT_W'(1));
    assign quotient = q_q;

endmodule

// File: rtl/multi_servo_pwm.sv
// N-channel servo PWM: calibrated ADC-to-pulse scaling with
// per-frame slew limiting and frame-aligned updates.
module multi_servo_pwm
    import servo_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int ADC_W         = 12,
    parameter int PERIOD        = DEF_PERIOD,
    parameter int PULSE_MIN     = DEF_PULSE_MIN,
    parameter int PULSE_MAX     = DEF_PULSE_MAX,
    parameter int PULSE_NEUTRAL = DEF_PULSE_NEU,
    parameter int SLEW_STEP     = DEF_SLEW_STEP,
    parameter int CH_W          = ch_width(NUM_CH),
    parameter int PW_W          = pw_width(PERIOD)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              adc_valid,
    output logic              adc_ready,
    input  logic [CH_W-1:0]   adc_ch,
    input  logic [ADC_W-1:0]  adc_data,
    input  logic              cal_we,
    input  logic [CH_W-1:0]   cal_ch,
    input  logic [ADC_W-1:0]  cal_min,
    input  logic [ADC_W-1:0]  cal_max,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] servo_pwm,
    output logic              frame_start,
    output logic [NUM_CH-1:0] cal_err
);

    localparam int NUM_W = ADC_W + PW_W;

    localparam logic [PW_W-1:0] LAST   = PW_W'(PERIOD - 1);
    localparam logic [PW_W-1:0] P_MIN  = PW_W'(PULSE_MIN);
    localparam logic [PW_W-1:0] P_NEU  = PW_W'(PULSE_NEUTRAL);
    localparam logic [PW_W-1:0] P_SPAN = PW_W'(PULSE_MAX - PULSE_MIN);
    localparam logic [PW_W-1:0] STEP_N = PW_W'(SLEW_STEP);
    localparam logic [PW_W:0]   STEP_W = (PW_W + 1)'(SLEW_STEP);
    localparam logic [CH_W:0]   CH_LIM = (CH_W + 1)'(NUM_CH);

    conv_state_t state_q;
    conv_state_t state_d;

    logic             accept;
    logic             ch_ok;
    logic             cal_ok;
    logic [CH_W-1:0]  cap_ch_q;
    logic [ADC_W-1:0] cap_x_q;
    logic [ADC_W-1:0] cap_lo_q;
    logic [ADC_W-1:0] cap_hi_q;
    logic             err_q;

    logic [ADC_W-1:0] x_clamp;
    logic [ADC_W-1:0] x_off;
    logic [ADC_W-1:0] span;
    logic             cal_bad;
    logic [NUM_W-1:0] num;
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [PW_W-1:0]  quotient;

    logic [ADC_W-1:0] cal_min_q [NUM_CH];
    logic [ADC_W-1:0] cal_max_q [NUM_CH];
    logic [PW_W-1:0]  target_q  [NUM_CH];
    logic [PW_W-1:0]  active_q  [NUM_CH];
    logic [NUM_CH-1:0] cal_err_q;

    logic [PW_W-1:0]   cnt_q;
    logic              last;
    logic              frame_start_q;
    logic [NUM_CH-1:0] pwm_q;

    function automatic logic [PW_W-1:0] slew(
        input logic [PW_W-1:0] tgt,
        input logic [PW_W-1:0] cur
    );
        logic [PW_W:0]   t;
        logic [PW_W:0]   c;
        logic [PW_W-1:0] r;
        t = {1'b0, tgt};
        c = {1'b0, cur};
        r = tgt;
        // Widened compares keep cur-step from wrapping below zero.
        if (SLEW_STEP != 0) begin
            if (t > c + STEP_W) begin
                r = cur + STEP_N;
            end else if (t + STEP_W < c) begin
                r = cur - STEP_N;
            end
        end
        return r;
    endfunction

    assign adc_ready = (state_q == ST_IDLE);
    assign accept    = adc_valid && adc_ready;
    assign ch_ok     = {1'b0, adc_ch} < CH_LIM;
    assign cal_ok    = {1'b0, cal_ch} < CH_LIM;

    always_comb begin
        x_clamp = cap_x_q;
        if (cap_x_q < cap_lo_q) begin
            x_clamp = cap_lo_q;
        end else if (cap_x_q > cap_hi_q) begin
            x_clamp = cap_hi_q;
        end
    end

    assign x_off     = x_clamp - cap_lo_q;
    assign span      = cap_hi_q - cap_lo_q;
    assign cal_bad   = cap_hi_q <= cap_lo_q;
    assign num       = NUM_W'(x_off) * NUM_W'(P_SPAN);
    assign div_start = (state_q == ST_PREP) && !cal_bad;

    seq_divider #(
        .NUM_W (NUM_W),
        .DEN_W (ADC_W),
        .Q_W   (PW_W)
    ) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start),
        .num      (num),
        .den      (span),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept && ch_ok) state_d = ST_PREP;
            ST_PREP:  state_d = cal_bad ? ST_WRITE : ST_DIV;
            ST_DIV:   if (div_done || !div_busy) state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cap_ch_q <= '0;
            cap_x_q  <= '0;
            cap_lo_q <= '0;
            cap_hi_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            // Table reads here see pre-write values on a same-cycle cal_we.
            if (accept && ch_ok) begin
                cap_ch_q <= adc_ch;
                cap_x_q  <= adc_data;
                cap_lo_q <= cal_min_q[adc_ch];
                cap_hi_q <= cal_max_q[adc_ch];
            end
            if (state_q == ST_PREP) begin
                err_q <= cal_bad;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cal_min_q[i] <= '0;
                cal_max_q[i] <= '1;
                target_q[i]  <= P_NEU;
            end
            cal_err_q <= '0;
        end else begin
            if (state_q == ST_WRITE) begin
                target_q[cap_ch_q] <= err_q ? P_NEU : P_MIN + quotient;
                if (err_q) begin
                    cal_err_q[cap_ch_q] <= 1'b1;
                end
            end
            if (cal_we && cal_ok) begin
                cal_min_q[cal_ch] <= cal_min;
                cal_max_q[cal_ch] <= cal_max;
                cal_err_q[cal_ch] <= (cal_max <= cal_min);
            end
        end
    end

    assign last = (cnt_q == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q         <= '0;
            frame_start_q <= 1'b0;
            pwm_q         <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                active_q[i] <= P_NEU;
            end
        end else begin
            cnt_q         <= last ? '0 : cnt_q + PW_W'(1);
            frame_start_q <= (cnt_q == '0);
            if (last) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    active_q[i] <= ch_en[i] ? slew(target_q[i], active_q[i])
                                            : P_NEU;
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_q[i] <= ch_en[i] && (cnt_q < active_q[i]);
            end
        end
    end

    assign servo_pwm   = pwm_q;
    assign frame_start = frame_start_q;
    assign cal_err     = cal_err_q;

endmodule
